// File: rtl/ocimem_monitor_ram.sv
// Debug monitor RAM shared between JTAG wrapper strobes and a CPU slave port.
// Optional CPU write protection: define OCIMEM_CPU_WPROT_EN.
module ocimem_monitor_ram #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest
);

  localparam int unsigned       DEPTH_U  = DEPTH;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {IDLE, J_RD, J_RDW, J_WR, C_RD, C_RDW, C_WR} state_t;

  state_t            state_q, state_d;
  logic              pend_q, pend_wr_q;
  logic [31:0]       pend_data_q;
  logic [ADDR_W-1:0] jaddr_q;
  logic [31:0]       mondreg_q;
  logic              ready_q, error_q, oor_q;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       rd_data_q;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic [31:0]       ram_wdata;

  logic strobe_any, busy, j_in_range, c_in_range, cpu_wr_allowed;

  assign strobe_any = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  // One op in flight: a pending op or an executing read/write rejects new strobes.
  assign busy       = pend_q | (state_q == J_RD) | (state_q == J_WR);
  assign j_in_range = (32'(jaddr_q) < DEPTH_U);
  assign c_in_range = (32'(cpu_address) < DEPTH_U);

`ifdef OCIMEM_CPU_WPROT_EN
  logic wprot_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wprot_q <= 1'b1;
    end else if (take_action_ocimem_a && !busy) begin
      wprot_q <= jdo[36];
    end
  end

  assign cpu_wr_allowed = ~wprot_q;
`else
  assign cpu_wr_allowed = 1'b1;
`endif

  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[1:0]};

  always_comb begin
    state_d   = state_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_waddr = jaddr_q;
    ram_raddr = jaddr_q;
    ram_wdata = pend_data_q;
    case (state_q)
      IDLE: begin
        // Hold off the CPU while a strobe lands so JTAG wins simultaneous requests.
        if (pend_q)              state_d = pend_wr_q ? J_WR : J_RD;
        else if (!strobe_any) begin
          if (cpu_read)          state_d = C_RD;
          else if (cpu_write)    state_d = C_WR;
        end
      end
      J_RD: begin
        ram_re  = j_in_range;
        state_d = J_RDW;
      end
      J_RDW: state_d = IDLE;
      J_WR: begin
        ram_we  = j_in_range;
        state_d = IDLE;
      end
      C_RD: begin
        ram_raddr = cpu_address;
        ram_re    = c_in_range;
        state_d   = C_RDW;
      end
      C_RDW: state_d = IDLE;
      C_WR: begin
        ram_waddr = cpu_address;
        ram_wdata = cpu_writedata;
        ram_we    = cpu_write & c_in_range & cpu_wr_allowed;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_re) rd_data_q <= mem[ram_raddr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      pend_wr_q   <= 1'b0;
      pend_data_q <= '0;
      jaddr_q     <= '0;
      mondreg_q   <= '0;
      ready_q     <= 1'b1;
      error_q     <= 1'b0;
      oor_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE:  if (pend_q) pend_q <= 1'b0;
        J_RD:  oor_q <= ~j_in_range;
        J_RDW: begin
          if (oor_q) error_q   <= 1'b1;
          else       mondreg_q <= rd_data_q;
          ready_q <= 1'b1;
          jaddr_q <= jaddr_q + ADDR_ONE;
        end
        J_WR: begin
          if (!j_in_range) error_q <= 1'b1;
          ready_q <= 1'b1;
          jaddr_q <= jaddr_q + ADDR_ONE;
        end
        C_RD:  oor_q <= ~c_in_range;
        default: ;
      endcase
      // Strobe handling comes last so a strobe accepted during J_RDW overrides its updates.
      if (strobe_any) begin
        if (busy) begin
          error_q <= 1'b1;
        end else if (take_action_ocimem_a) begin
          jaddr_q <= jdo[ADDR_W+1:2];
          error_q <= 1'b0;
          if (jdo[35]) begin
            pend_q    <= 1'b1;
            pend_wr_q <= 1'b0;
            ready_q   <= 1'b0;
          end
        end else if (take_action_ocimem_b) begin
          pend_q      <= 1'b1;
          pend_wr_q   <= 1'b1;
          pend_data_q <= jdo[34:3];
          ready_q     <= 1'b0;
        end else begin
          pend_q    <= 1'b1;
          pend_wr_q <= 1'b0;
          ready_q   <= 1'b0;
        end
      end
    end
  end

  assign MonDReg         = mondreg_q;
  assign monitor_ready   = ready_q;
  assign monitor_error   = error_q;
  assign cpu_readdata    = (state_q == C_RDW && !oor_q) ? rd_data_q : '0;
  assign cpu_waitrequest = reset | ~((state_q == C_WR) | (state_q == C_RDW));

endmodule
